// File: rtl/crt_timing_pkg.sv
// -----------------------------------------------------------------------------
// crt_timing_pkg
// Shared definitions for the CRT timing engine:
//   - default widths for the timing-field inputs (RES_W) and divider (DIV_W)
//   - timing_set_t: one complete video mode (4 horizontal + 4 vertical fields)
//   - VGA 640x480 reference mode
// -----------------------------------------------------------------------------
package crt_timing_pkg;

  localparam int RES_W_DEF = 10;
  localparam int DIV_W_DEF = 4;

  // One video mode; fields sized for the default RES_W.
  typedef struct packed {
    logic [RES_W_DEF-1:0] h_active;
    logic [RES_W_DEF-1:0] h_front;
    logic [RES_W_DEF-1:0] h_sync;
    logic [RES_W_DEF-1:0] h_back;
    logic [RES_W_DEF-1:0] v_active;
    logic [RES_W_DEF-1:0] v_front;
    logic [RES_W_DEF-1:0] v_sync;
    logic [RES_W_DEF-1:0] v_back;
  } timing_set_t;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FRONT  = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BACK   = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FRONT  = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BACK   = 33;

  localparam timing_set_t VGA_640X480 = '{
    h_active: RES_W_DEF'(VGA_H_ACTIVE),
    h_front:  RES_W_DEF'(VGA_H_FRONT),
    h_sync:   RES_W_DEF'(VGA_H_SYNC),
    h_back:   RES_W_DEF'(VGA_H_BACK),
    v_active: RES_W_DEF'(VGA_V_ACTIVE),
    v_front:  RES_W_DEF'(VGA_V_FRONT),
    v_sync:   RES_W_DEF'(VGA_V_SYNC),
    v_back:   RES_W_DEF'(VGA_V_BACK)
  };

endpackage

// File: rtl/crt_timing_if.sv
// -----------------------------------------------------------------------------
// crt_timing_if
// Bundles the control/geometry inputs and the video timing outputs of the
// CRT timing engine.
//   master : drives Enable, ClockDivide, geometry fields, sync polarities;
//            observes PixelClock, xpos/ypos, hsync/vsync, ActiveVideo,
//            LineEnd, FrameEnd.
//   slave  : the timing engine (mirror directions).
// Parameters RES_W / DIV_W must match those of the engine instance.
// -----------------------------------------------------------------------------
interface crt_timing_if import crt_timing_pkg::*; #(
  parameter int RES_W = RES_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) ();

  logic             Enable;
  logic [DIV_W-1:0] ClockDivide;
  logic [RES_W-1:0] hActive;
  logic [RES_W-1:0] hFront;
  logic [RES_W-1:0] hSync;
  logic [RES_W-1:0] hBack;
  logic [RES_W-1:0] vActive;
  logic [RES_W-1:0] vFront;
  logic [RES_W-1:0] vSync;
  logic [RES_W-1:0] vBack;
  logic             hsyncPolarity;
  logic             vsyncPolarity;

  logic             PixelClock;
  logic [RES_W+1:0] xpos;
  logic [RES_W+1:0] ypos;
  logic             hsync;
  logic             vsync;
  logic             ActiveVideo;
  logic             LineEnd;
  logic             FrameEnd;

  modport master (
    output Enable, ClockDivide,
    output hActive, hFront, hSync, hBack,
    output vActive, vFront, vSync, vBack,
    output hsyncPolarity, vsyncPolarity,
    input  PixelClock, xpos, ypos, hsync, vsync, ActiveVideo, LineEnd, FrameEnd
  );

  modport slave (
    input  Enable, ClockDivide,
    input  hActive, hFront, hSync, hBack,
    input  vActive, vFront, vSync, vBack,
    input  hsyncPolarity, vsyncPolarity,
    output PixelClock, xpos, ypos, hsync, vsync, ActiveVideo, LineEnd, FrameEnd
  );

endinterface

// File: rtl/crt_pixel_divider.sv
// -----------------------------------------------------------------------------
// crt_pixel_divider
// Generates a one-Clock pixel-tick enable every ClockDivide+1 Clocks.
// Ports:
//   ClockDivide : divide ratio minus one (0 -> tick every Clock)
//   Enable      : count when high; low clears the count and blocks ticks
//   PixelClock  : tick enable pulse (never asserted while Reset or Enable low)
//   Reset       : synchronous, active-low
//   Clock       : system clock
// -----------------------------------------------------------------------------
module crt_pixel_divider import crt_timing_pkg::*; #(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic [DIV_W-1:0] ClockDivide,
  input  logic             Enable,
  output logic             PixelClock,
  input  logic             Reset,
  input  logic             Clock
);

  logic [DIV_W-1:0] count;
  logic             at_end;

  // >= rather than == so a live shrink of ClockDivide below the current
  // count ends the period immediately instead of running the count around.
  assign at_end = (count >= ClockDivide);

  always_ff @(posedge Clock) begin
    if (!Reset || !Enable || at_end) begin
      count <= '0;
    end else begin
      count <= count + DIV_W'(1);
    end
  end

  assign PixelClock = Reset & Enable & at_end;

endmodule

// File: rtl/crt_timing_engine.sv
// -----------------------------------------------------------------------------
// crt_timing_engine
// Programmable CRT/VGA raster timing generator. Each line and frame is laid
// out as active, front porch, sync, back porch. Counters advance on pixel
// ticks from crt_pixel_divider; hsync/vsync/ActiveVideo are decoded from the
// next counter values and registered on the tick so they line up with
// xpos/ypos.
// Ports:
//   Clock : system clock (rising edge)
//   Reset : synchronous, active-low; overrides Enable
//   bus   : crt_timing_if.slave (Enable, ClockDivide, geometry, polarities in;
//           PixelClock, xpos, ypos, hsync, vsync, ActiveVideo, LineEnd,
//           FrameEnd out)
// Build option:
//   CRT_SHADOW_REG_EN : geometry is shadowed during reset and at every
//                       FrameEnd so mid-frame edits apply from the next frame.
//                       Undefined: geometry inputs are used live.
// -----------------------------------------------------------------------------
module crt_timing_engine import crt_timing_pkg::*; #(
  parameter int RES_W = RES_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic          Clock,
  input  logic          Reset,
  crt_timing_if.slave   bus
);

  localparam int CW = RES_W + 2;
  typedef logic [CW-1:0]    cnt_t;
  typedef logic [RES_W-1:0] fld_t;

  // Segment sum at counter width (cannot overflow); an empty line/frame
  // is treated as one unit long so the wrap compare stays meaningful.
  function automatic cnt_t seg_total(fld_t a, fld_t b, fld_t c, fld_t d);
    cnt_t s;
    s = cnt_t'(a) + cnt_t'(b) + cnt_t'(c) + cnt_t'(d);
    return (s == '0) ? cnt_t'(1) : s;
  endfunction

  // Sync window [active+front, active+front+sync); a zero-length sync
  // yields an empty window.
  function automatic logic in_sync(cnt_t pos, fld_t act, fld_t front, fld_t len);
    cnt_t start;
    start = cnt_t'(act) + cnt_t'(front);
    return (pos >= start) && (pos < start + cnt_t'(len));
  endfunction

  function automatic logic sync_level(logic active, logic polarity);
    return polarity ? active : ~active;
  endfunction

  logic tick;
  logic x_wrap, y_wrap;
  logic line_end, frame_end;

  crt_pixel_divider #(.DIV_W(DIV_W)) u_divider (
    .ClockDivide (bus.ClockDivide),
    .Enable      (bus.Enable),
    .PixelClock  (tick),
    .Reset       (Reset),
    .Clock       (Clock)
  );

  // cur_* sets the line/frame length for wrap decisions; dec_* feeds the
  // sync/active decode of the next counter values.
  fld_t cur_h_active, cur_h_front, cur_h_sync, cur_h_back;
  fld_t cur_v_active, cur_v_front, cur_v_sync, cur_v_back;
  fld_t dec_h_active, dec_h_front, dec_h_sync;
  fld_t dec_v_active, dec_v_front, dec_v_sync;

`ifdef CRT_SHADOW_REG_EN
  fld_t sh_h_active, sh_h_front, sh_h_sync, sh_h_back;
  fld_t sh_v_active, sh_v_front, sh_v_sync, sh_v_back;

  always_ff @(posedge Clock) begin
    if (!Reset || frame_end) begin
      sh_h_active <= bus.hActive;
      sh_h_front  <= bus.hFront;
      sh_h_sync   <= bus.hSync;
      sh_h_back   <= bus.hBack;
      sh_v_active <= bus.vActive;
      sh_v_front  <= bus.vFront;
      sh_v_sync   <= bus.vSync;
      sh_v_back   <= bus.vBack;
    end
  end

  assign cur_h_active = sh_h_active;
  assign cur_h_front  = sh_h_front;
  assign cur_h_sync   = sh_h_sync;
  assign cur_h_back   = sh_h_back;
  assign cur_v_active = sh_v_active;
  assign cur_v_front  = sh_v_front;
  assign cur_v_sync   = sh_v_sync;
  assign cur_v_back   = sh_v_back;

  // Pixel (0,0) decoded on the FrameEnd tick belongs to the new frame, so
  // it is decoded with the geometry being captured on that same edge.
  assign dec_h_active = frame_end ? bus.hActive : sh_h_active;
  assign dec_h_front  = frame_end ? bus.hFront  : sh_h_front;
  assign dec_h_sync   = frame_end ? bus.hSync   : sh_h_sync;
  assign dec_v_active = frame_end ? bus.vActive : sh_v_active;
  assign dec_v_front  = frame_end ? bus.vFront  : sh_v_front;
  assign dec_v_sync   = frame_end ? bus.vSync   : sh_v_sync;
`else
  assign cur_h_active = bus.hActive;
  assign cur_h_front  = bus.hFront;
  assign cur_h_sync   = bus.hSync;
  assign cur_h_back   = bus.hBack;
  assign cur_v_active = bus.vActive;
  assign cur_v_front  = bus.vFront;
  assign cur_v_sync   = bus.vSync;
  assign cur_v_back   = bus.vBack;

  assign dec_h_active = bus.hActive;
  assign dec_h_front  = bus.hFront;
  assign dec_h_sync   = bus.hSync;
  assign dec_v_active = bus.vActive;
  assign dec_v_front  = bus.vFront;
  assign dec_v_sync   = bus.vSync;
`endif

  cnt_t htotal, vtotal;
  assign htotal = seg_total(cur_h_active, cur_h_front, cur_h_sync, cur_h_back);
  assign vtotal = seg_total(cur_v_active, cur_v_front, cur_v_sync, cur_v_back);

  // ---- stage p0: next counter values and their decode ----
  cnt_t xpos_p1, ypos_p1;
  cnt_t x_p0, y_p0;
  logic hsync_p0, vsync_p0, active_p0;

  always_comb begin
    x_p0   = xpos_p1;
    y_p0   = ypos_p1;
    // >= keeps the counters bounded after a live shrink of the geometry.
    x_wrap = (xpos_p1 >= htotal - cnt_t'(1));
    y_wrap = (ypos_p1 >= vtotal - cnt_t'(1));
    if (x_wrap) begin
      x_p0 = '0;
      y_p0 = y_wrap ? '0 : ypos_p1 + cnt_t'(1);
    end else begin
      x_p0 = xpos_p1 + cnt_t'(1);
    end
    hsync_p0  = sync_level(in_sync(x_p0, dec_h_active, dec_h_front, dec_h_sync),
                           bus.hsyncPolarity);
    vsync_p0  = sync_level(in_sync(y_p0, dec_v_active, dec_v_front, dec_v_sync),
                           bus.vsyncPolarity);
    active_p0 = (x_p0 < cnt_t'(dec_h_active)) && (y_p0 < cnt_t'(dec_v_active));
  end

  assign line_end  = tick & x_wrap;
  assign frame_end = line_end & y_wrap;

  // ---- stage p1: registered counters and video outputs ----
  logic hsync_p1, vsync_p1, active_p1;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      xpos_p1   <= '0;
      ypos_p1   <= '0;
      hsync_p1  <= ~bus.hsyncPolarity;
      vsync_p1  <= ~bus.vsyncPolarity;
      active_p1 <= 1'b0;
    end else if (tick) begin
      xpos_p1   <= x_p0;
      ypos_p1   <= y_p0;
      hsync_p1  <= hsync_p0;
      vsync_p1  <= vsync_p0;
      active_p1 <= active_p0;
    end
  end

  assign bus.PixelClock  = tick;
  assign bus.xpos        = xpos_p1;
  assign bus.ypos        = ypos_p1;
  assign bus.hsync       = hsync_p1;
  assign bus.vsync       = vsync_p1;
  assign bus.ActiveVideo = active_p1;
  assign bus.LineEnd     = line_end;
  assign bus.FrameEnd    = frame_end;

endmodule
